// File: rtl/adc_chan_align.sv
// Multi-channel ADC capture: IOB input register, offset-binary to two's-complement conversion,
// programmable per-channel delay line with clamped tap load, settle flag and sticky overrange.
module adc_chan_align #(
  parameter int NCH        = 3,
  parameter int WIDTH      = 13,
  parameter int DEPTH      = 32,
  parameter int TAPW       = 5,
  parameter int OFFSET_BIN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*WIDTH-1:0]  din,
  input  logic [1:0]            sr_bypass,
  input  logic [NCH*TAPW-1:0]   sr_tap,
  input  logic                  tap_load,
  input  logic                  ovr_clr,
  output logic [NCH*WIDTH-1:0]  dout,
  output logic                  dout_valid,
  output logic [NCH-1:0]        ovr
);

  localparam logic [WIDTH-1:0] FLIP     = (OFFSET_BIN != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
  localparam logic [WIDTH-1:0] MID      = FLIP;
  localparam logic [WIDTH-1:0] CONV_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] CONV_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam int               CNTW     = $clog2(DEPTH + 4);
  localparam logic [CNTW-1:0]  SETTLE   = CNTW'(DEPTH + 3);
  localparam logic [TAPW-1:0]  TAP_MAX  = TAPW'(DEPTH - 1);

  logic [CNTW-1:0] settle_cnt;

  // Settle counter only advances while the delay lines actually move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= SETTLE;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= (settle_cnt == '0);
      if (tap_load)
        settle_cnt <= SETTLE;
      else if (sr_bypass[1] && (settle_cnt != '0))
        settle_cnt <= settle_cnt - 1'b1;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    (* IOB = "TRUE" *) logic [WIDTH-1:0] in_reg;
    logic [WIDTH-1:0] sr [DEPTH];
    logic [TAPW-1:0]  tap_act;
    logic [TAPW-1:0]  tap_req;
    logic [WIDTH-1:0] tap_dat;
    logic [WIDTH-1:0] in_conv;
    logic [WIDTH-1:0] dout_q;
    logic             ovr_q;

    assign tap_req = sr_tap[c*TAPW +: TAPW];
    assign in_conv = in_reg ^ FLIP;

    always_comb begin
      tap_dat = MID;
      for (int k = 0; k < DEPTH; k++)
        if (tap_act == TAPW'(k))
          tap_dat = sr[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        in_reg <= MID;
      else
        in_reg <= din[c*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < DEPTH; k++)
          sr[k] <= MID;
      end else if (sr_bypass[1]) begin
        sr[0] <= in_reg;
        for (int k = 1; k < DEPTH; k++)
          sr[k] <= sr[k-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        tap_act <= '0;
      else if (tap_load)
        tap_act <= (tap_req > TAP_MAX) ? TAP_MAX : tap_req;
    end

    // Raw extremes map to the converted min/max regardless of input format; set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
        ovr_q  <= 1'b0;
      end else begin
        dout_q <= sr_bypass[0] ? in_conv : (tap_dat ^ FLIP);
        ovr_q  <= (in_conv == CONV_MIN) || (in_conv == CONV_MAX) || (ovr_q && !ovr_clr);
      end
    end

    assign dout[c*WIDTH +: WIDTH] = dout_q;
    assign ovr[c]                 = ovr_q;
  end

endmodule

// File: tb/tb_adc_chan_align.sv
// Bench for adc_chan_align: table vectors, directed corner sequences and a randomized run
// checked against an arithmetic history model, over three builds (default, DEPTH=20, two's-complement input).
module tb_adc_chan_align;

  localparam int DEP [3] = '{32, 20, 8};
  localparam bit OB  [3] = '{1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [38:0] din;
  logic [1:0]  byp;
  logic [14:0] tap;
  logic        tl, clr;
  logic [38:0] dout_o [3];
  logic        vld_o  [3];
  logic [2:0]  ovr_o  [3];

  always #5 clk = ~clk;

  adc_chan_align u0 (
    .clk(clk), .rst_n(rst_n), .din(din), .sr_bypass(byp), .sr_tap(tap), .tap_load(tl),
    .ovr_clr(clr), .dout(dout_o[0]), .dout_valid(vld_o[0]), .ovr(ovr_o[0]));
  adc_chan_align #(.DEPTH(20)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din), .sr_bypass(byp), .sr_tap(tap), .tap_load(tl),
    .ovr_clr(clr), .dout(dout_o[1]), .dout_valid(vld_o[1]), .ovr(ovr_o[1]));
  adc_chan_align #(.DEPTH(8), .OFFSET_BIN(0)) u2 (
    .clk(clk), .rst_n(rst_n), .din(din), .sr_bypass(byp), .sr_tap(tap), .tap_load(tl),
    .ovr_clr(clr), .dout(dout_o[2]), .dout_valid(vld_o[2]), .ovr(ovr_o[2]));

  int nvec = 0;
  int nerr = 0;

  // Reference model: each channel keeps the history of samples shifted into its line.
  logic [12:0] m_in   [3][3];
  logic [12:0] m_hist [3][3][64];
  int          m_tap  [3][3];
  logic [12:0] m_dout [3][3];
  bit          m_ovr  [3][3];
  int          m_cnt  [3];
  bit          m_vld  [3];

  function automatic logic [12:0] mconv(input bit ob, input logic [12:0] x);
    if (ob) return 13'(int'(x) - 4096);
    return x;
  endfunction

  function automatic bit mext(input bit ob, input logic [12:0] x);
    int v;
    if (ob) return (x == 13'd0) || (x == 13'd8191);
    v = int'($signed(x));
    return (v == -4096) || (v == 4095);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 3; c++) begin
        m_in[i][c]   = OB[i] ? 13'd4096 : 13'd0;
        for (int k = 0; k < 64; k++) m_hist[i][c][k] = m_in[i][c];
        m_tap[i][c]  = 0;
        m_dout[i][c] = '0;
        m_ovr[i][c]  = 1'b0;
      end
      m_cnt[i] = DEP[i] + 3;
      m_vld[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 3; c++) begin
        int req;
        m_dout[i][c] = mconv(OB[i], byp[0] ? m_in[i][c] : m_hist[i][c][m_tap[i][c]]);
        m_ovr[i][c]  = mext(OB[i], m_in[i][c]) || (m_ovr[i][c] && !clr);
        if (byp[1]) begin
          for (int k = 63; k > 0; k--) m_hist[i][c][k] = m_hist[i][c][k-1];
          m_hist[i][c][0] = m_in[i][c];
        end
        m_in[i][c] = din[c*13 +: 13];
        req = int'(tap[c*5 +: 5]);
        if (tl) m_tap[i][c] = (req > DEP[i] - 1) ? DEP[i] - 1 : req;
      end
      m_vld[i] = (m_cnt[i] == 0);
      if (tl) m_cnt[i] = DEP[i] + 3;
      else if (byp[1] && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic [38:0] e;
      logic [2:0]  eo;
      for (int c = 0; c < 3; c++) begin
        e[c*13 +: 13] = m_dout[i][c];
        eo[c]         = m_ovr[i][c];
      end
      chk($sformatf("u%0d_dout", i), 64'(dout_o[i]), 64'(e));
      chk($sformatf("u%0d_valid", i), 64'(vld_o[i]), 64'(m_vld[i]));
      chk($sformatf("u%0d_ovr", i), 64'(ovr_o[i]), 64'(eo));
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  typedef struct {
    logic [12:0] raw;
    logic [12:0] exp;
  } vec_t;
  vec_t tbl [8];

  localparam logic [38:0] MIDV = {3{13'h1000}};

  initial begin
    logic [38:0] e;
    logic [12:0] prev;

    tbl[0] = '{13'h0000, 13'h1000};
    tbl[1] = '{13'h0001, 13'h1001};
    tbl[2] = '{13'h0002, 13'h1002};
    tbl[3] = '{13'h1000, 13'h0000};
    tbl[4] = '{13'h1FFF, 13'h0FFF};
    tbl[5] = '{13'h0FFF, 13'h1FFF};
    tbl[6] = '{13'h1400, 13'h0400};
    tbl[7] = '{13'h0C00, 13'h1C00};

    din = MIDV; byp = 2'b10; tap = '0; tl = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout", 64'(dout_o[0]), 64'd0);
    chk("reset_valid", 64'(vld_o[0]), 64'd0);
    chk("reset_ovr", 64'(ovr_o[0]), 64'd0);
    check_all();
    rst_n = 1'b1;

    // Midscale in, shifting: output stays zero, valid rises on the 36th edge.
    for (int k = 1; k <= 36; k++) begin
      step();
      chk("mid_dout", 64'(dout_o[0]), 64'd0);
      if (k == 35) chk("settle_lo", 64'(vld_o[0]), 64'd0);
      if (k == 36) chk("settle_hi", 64'(vld_o[0]), 64'd1);
    end

    // Bypass table: one edge later still the previous value, two edges later the new one.
    byp = 2'b01;
    prev = '0;
    for (int i = 0; i < 8; i++) begin
      din = {3{tbl[i].raw}};
      step();
      chk("byp_lat1", 64'(dout_o[0]), 64'({3{prev}}));
      step();
      chk("byp_lat2", 64'(dout_o[0]), 64'({3{tbl[i].exp}}));
      prev = tbl[i].exp;
    end

    // Impulse through taps {0,7,31}; u1 clamps 31 to 19.
    byp = 2'b10; din = MIDV;
    repeat (40) step();
    tap = {5'd31, 5'd7, 5'd0}; tl = 1'b1;
    step();
    tl = 1'b0;
    din = {3{13'h1400}};
    for (int j = 1; j <= 40; j++) begin
      step();
      din = MIDV;
      e = '0;
      if (j == 3)  e[12:0]  = 13'h0400;
      if (j == 10) e[25:13] = 13'h0400;
      if (j == 34) e[38:26] = 13'h0400;
      chk("imp_dout", 64'(dout_o[0]), 64'(e));
      chk("imp_valid", 64'(vld_o[0]), 64'(j >= 36));
      chk("clamp_dout", 64'(dout_o[1][38:26]), (j == 22) ? 64'h400 : 64'h0);
    end

    // Sticky overrange and set-over-clear priority.
    clr = 1'b1; step(); clr = 1'b0;
    chk("ovr_cleared", 64'(ovr_o[0]), 64'd0);
    din = {13'h1000, 13'h1FFF, 13'h1000};
    step();
    chk("ovr_lat1", 64'(ovr_o[0]), 64'd0);
    din = MIDV;
    step();
    chk("ovr_set", 64'(ovr_o[0]), 64'b010);
    repeat (3) step();
    chk("ovr_sticky", 64'(ovr_o[0]), 64'b010);
    din = {13'h1000, 13'h0000, 13'h1000};
    step();
    din = MIDV; clr = 1'b1;
    step();
    chk("ovr_set_wins", 64'(ovr_o[0]), 64'b010);
    step();
    clr = 1'b0;
    chk("ovr_clr", 64'(ovr_o[0]), 64'd0);

    // Freeze: shift disabled holds the count and the tapped output.
    tap = {5'd25, 5'd12, 5'd3}; tl = 1'b1;
    step();
    tl = 1'b0;
    repeat (10) begin
      din = {$urandom_range(0, 8191), $urandom_range(0, 8191), $urandom_range(0, 8191)};
      din = {din[38:26] & 13'h1FFF, din[25:13], din[12:0]};
      step();
    end
    byp = 2'b00;
    for (int k = 0; k < 50; k++) begin
      din = {13'($urandom), 13'($urandom), 13'($urandom)};
      step();
      chk("freeze_valid", 64'(vld_o[0]), 64'd0);
    end
    byp = 2'b10;
    for (int r = 1; r <= 26; r++) begin
      din = {13'($urandom), 13'($urandom), 13'($urandom)};
      step();
      if (r == 25) chk("resume_lo", 64'(vld_o[0]), 64'd0);
      if (r == 26) chk("resume_hi", 64'(vld_o[0]), 64'd1);
    end

    // Asynchronous reset mid-settle.
    tl = 1'b1; step(); tl = 1'b0;
    din = {13'h1000, 13'h1000, 13'h0000};
    repeat (2) step();
    din = MIDV;
    step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_dout", 64'(dout_o[0]), 64'd0);
    chk("arst_valid", 64'(vld_o[0]), 64'd0);
    chk("arst_ovr", 64'(ovr_o[0]), 64'd0);
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized run against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < 3; c++) begin
        case ($urandom_range(0, 9))
          0:       din[c*13 +: 13] = 13'h0000;
          1:       din[c*13 +: 13] = 13'h1FFF;
          2:       din[c*13 +: 13] = 13'h0FFF;
          3:       din[c*13 +: 13] = 13'h1000;
          default: din[c*13 +: 13] = 13'($urandom);
        endcase
      end
      if ($urandom_range(0, 7) == 0) byp = 2'($urandom);
      tl  = ($urandom_range(0, 40) == 0);
      tap = 15'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
